// File: rtl/bview_stream.sv
// bview_stream: streams the flattened 1D view of a binary feature tensor as CHUNK-bit beats.
// Optional BVIEW_STREAM_DBUF_EN adds a shadow buffer so tensors stream back-to-back.
module bview_stream #(
  parameter int ISIZE_W    = 64,
  parameter int ISIZE_H    = 64,
  parameter int ISIZE_FEAT = 1,
  parameter int OSIZE_FEAT = 4096,
  parameter int CHUNK      = 32
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           in_valid_i,
  output logic                                           in_ready_o,
  input  logic [ISIZE_FEAT-1:0][ISIZE_W-1:0][ISIZE_H-1:0] layer_i,
  output logic                                           out_valid_o,
  input  logic                                           out_ready_i,
  output logic [CHUNK-1:0]                               out_data_o,
  output logic                                           out_last_o,
  output logic                                           busy_o
);
  localparam int S  = ISIZE_W * ISIZE_H;
  localparam int NB = (OSIZE_FEAT + CHUNK - 1) / CHUNK;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int PW = NB * CHUNK;

  if (OSIZE_FEAT != ISIZE_FEAT * ISIZE_W * ISIZE_H) begin : g_size_err
    $error("bview_stream: OSIZE_FEAT must equal ISIZE_FEAT*ISIZE_W*ISIZE_H");
  end
  if (CHUNK < 1 || CHUNK > OSIZE_FEAT) begin : g_chunk_err
    $error("bview_stream: CHUNK must be in 1..OSIZE_FEAT");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   flat_in, main_q, main_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            in_hs, out_hs, last_beat, wrap;

  assign in_hs     = in_valid_i && in_ready_o;
  assign out_hs    = out_valid_o && out_ready_i;
  assign last_beat = beat_q == BW'(NB - 1);
  assign wrap      = out_hs && last_beat;

`ifdef BVIEW_STREAM_DBUF_EN
  logic [PW-1:0] shad_q, shad_d;
  logic          full_q, full_d;
`endif

  // Flatten the tensor with reversed feature order; padding bits above OSIZE_FEAT stay 0.
  always_comb begin
    flat_in = '0;
    for (int k = 0; k < ISIZE_FEAT; k++) flat_in[k*S +: S] = layer_i[ISIZE_FEAT-1-k];
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: leave SEND only after the last beat when nothing is queued behind it.
  always_comb begin
`ifdef BVIEW_STREAM_DBUF_EN
    state_d = state_q == IDLE ? (in_hs ? SEND : IDLE) : (wrap && !full_q && !in_hs ? IDLE : SEND);
`else
    state_d = state_q == IDLE ? (in_hs ? SEND : IDLE) : (wrap ? IDLE : SEND);
`endif
  end

  // Outputs derive from registered state only; ready is forced low while in reset.
  always_comb begin
    busy_o      = state_q == SEND;
    out_valid_o = busy_o;
    out_last_o  = busy_o && last_beat;
    out_data_o  = busy_o ? main_q[int'(beat_q)*CHUNK +: CHUNK] : '0;
`ifdef BVIEW_STREAM_DBUF_EN
    in_ready_o  = !rst_i && !full_q;
`else
    in_ready_o  = !rst_i && state_q == IDLE;
`endif
  end

  // Buffer and beat-counter next state.
  always_comb begin
    main_d = main_q;
    beat_d = beat_q;
    if (state_q == IDLE && in_hs) begin
      main_d = flat_in;
      beat_d = '0;
    end else if (out_hs) beat_d = last_beat ? '0 : beat_q + 1'b1;
`ifdef BVIEW_STREAM_DBUF_EN
    shad_d = shad_q;
    full_d = full_q;
    if (state_q == SEND && in_hs && !wrap) begin
      shad_d = flat_in;
      full_d = 1'b1;
    end
    if (wrap) begin
      main_d = full_q ? shad_q : in_hs ? flat_in : main_q;
      full_d = 1'b0;
    end
`endif
  end

  // Datapath registers; reset discards any tensor in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q <= '0;
      beat_q <= '0;
`ifdef BVIEW_STREAM_DBUF_EN
      shad_q <= '0;
      full_q <= 1'b0;
`endif
    end else begin
      main_q <= main_d;
      beat_q <= beat_d;
`ifdef BVIEW_STREAM_DBUF_EN
      shad_q <= shad_d;
      full_q <= full_d;
`endif
    end
  end
endmodule

// File: doc/bview_stream.md
# bview_stream

Sequential successor of the combinational 3D-to-1D view block. It captures a binary feature tensor on a valid/ready input port and emits its flattened 1D view as a stream of `CHUNK`-bit beats on a valid/ready output port. Downstream fully-connected stages can then consume the view serially instead of through one `OSIZE_FEAT`-wide bus. It sits between the last convolutional/pooling layer and the first dense layer.

## Interface
- `ISIZE_W`, 64, tensor width
- `ISIZE_H`, 64, tensor height
- `ISIZE_FEAT`, 1, feature channels
- `OSIZE_FEAT`, 4096, flat length; must equal `ISIZE_FEAT*ISIZE_W*ISIZE_H` (elaboration `$error` otherwise)
- `CHUNK`, 32, bits per output beat, 1..`OSIZE_FEAT`
- `clk_i` in 1: single clock, rising edge
- `rst_i` in 1: asynchronous, active-high reset
- `in_valid_i` in 1: tensor valid
- `in_ready_o` out 1: tensor accepted when `in_valid_i && in_ready_o`
- `layer_i` in `[ISIZE_FEAT-1:0][ISIZE_W-1:0][ISIZE_H-1:0]`: tensor
- `out_valid_o` out 1: beat valid
- `out_ready_i` in 1: beat consumed when `out_valid_o && out_ready_i`
- `out_data_o` out `CHUNK`: beat payload
- `out_last_o` out 1: final beat of a tensor
- `busy_o` out 1: state is SEND

## Operation
- Flat mapping: `flat[k*S + i*ISIZE_H + h] = layer_i[ISIZE_FEAT-1-k][i][h]`, where `S = ISIZE_W*ISIZE_H`.
  - Feature order is reversed: flat block 0 holds feature `ISIZE_FEAT-1`.
- Beat count: `NB = ceil(OSIZE_FEAT/CHUNK)`.
  - Beat `b` carries `flat[b*CHUNK +: CHUNK]`.
  - Bits beyond `OSIZE_FEAT` in the last beat are 0.
- Beat counter `beat_q` is `max(1,$clog2(NB))` bits and counts 0..NB-1 with no wrap past NB-1.
- FSM:
  - IDLE: `in_ready_o=1`. On input handshake, register the tensor into the main buffer, set `beat_q=0`, go to SEND.
  - SEND: `out_valid_o=1`. On output handshake, `beat_q++`. On a handshake with `beat_q==NB-1`, go to IDLE (subject to the DBUF rules below).
- `out_last_o = busy_o && beat_q==NB-1`.
- `out_data_o` is 0 whenever `out_valid_o=0`.
- While `out_valid_o && !out_ready_i`, `out_data_o`, `out_last_o` and `beat_q` are held.
- `layer_i` is sampled only at the input handshake. Later changes do not affect beats in flight.
- `NB==1` (`CHUNK>=OSIZE_FEAT`): a single beat with `out_last_o=1`.

## Timing
- Reset (`rst_i` high, asynchronous) forces:
  - state IDLE, `beat_q=0`, buffers 0
  - `out_valid_o=0`, `out_last_o=0`, `busy_o=0`, `out_data_o=0`
  - `in_ready_o=0` while `rst_i` is high; `in_ready_o=1` on the first cycle after release
- Reset mid-stream discards the tensor. No further beats are emitted.
- Latency: input handshake at edge N → first beat valid in the cycle after edge N.
- `out_data_o` and `out_last_o` are combinational from registered state. No combinational path from `out_ready_i` to `out_valid_o`.
- Non-DBUF throughput: one tensor per NB+1 cycles with `out_ready_i` held high.

## Configuration
- `BVIEW_STREAM_DBUF_EN` defined adds a shadow buffer plus a full flag.
  - `in_ready_o = !shadow_full` in any state.
  - In IDLE, an accepted tensor goes to the main buffer.
  - In SEND, an accepted tensor goes to the shadow buffer.
  - Last-beat handshake with shadow full: shadow moves to main, `beat_q=0`, stay in SEND. Back-to-back, no bubble.
  - Input handshake and last-beat handshake in the same cycle with shadow empty: the new tensor loads directly into main, stay in SEND.
  - Throughput: one tensor per NB cycles.
- Macro undefined: no shadow buffer. `in_ready_o` is high only in IDLE, and at least one idle cycle separates tensors.

## Test plan
- Parameters W=2, H=2, FEAT=2, OSIZE=8, CHUNK=3. Input `layer_i[1]=4'b1010`, `layer_i[0]=4'b0011` (flat `8'h3A`), `out_ready_i=1` → beats `3'd2`, `3'd7`, `3'd0`, with `out_last_o` only on the third, then IDLE.
- Same tensor, `out_ready_i` low for 4 cycles during beat 1 → `3'd7` held stable with `out_valid_o=1`. Stream resumes with no lost or duplicated beat.
- Change `layer_i` to all ones during SEND → beats still `2`, `7`, `0`.
- Assert `rst_i` during beat 1 → outputs 0 immediately (asynchronous). The next tensor after release streams from beat 0.
- CHUNK=8 → a single beat `8'h3A` with `out_last_o=1`.
- DBUF defined: two tensors offered back-to-back (`8'h3A`, then `8'hFF`) → 6 contiguous valid beats `2,7,0,7,7,3`. `in_ready_o` drops while the shadow is full.
